// File: rtl/random_mask_gen.sv
// Multi-channel pseudo-random stall-mask generator for the delay-RAM interface.
// Per channel: maximal-length LFSR, burst phase counter, and a bounded-run guard on the registered mask.
module random_mask_gen #(
  parameter int                NUM_CH  = 2,
  parameter int                LFSR_W  = 23,
  parameter logic [LFSR_W-1:0] SEED    = {LFSR_W{1'b1}},
  parameter int                MAX_RUN = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        mode,
  input  logic [3:0]        density,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  output logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] guard_hit
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_RANDOM = 2'b01,
    MODE_BURST  = 2'b10,
    MODE_FORCE  = 2'b11
  } mode_e;

  // Trinomial taps x^W + x^T + 1 that give a maximal-length sequence.
  function automatic int tap_for(input int w);
    case (w)
      7:       return 6;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return w - 1;
    endcase
  endfunction

  localparam int              TAP      = tap_for(LFSR_W);
  localparam int              RUN_W    = (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
  localparam logic            GUARD_EN = (MAX_RUN != 0);

  if (!(LFSR_W == 7 || LFSR_W == 15 || LFSR_W == 23 || LFSR_W == 31)) begin : g_bad_lfsr_w
    $error("random_mask_gen: LFSR_W must be 7, 15, 23 or 31");
  end
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("random_mask_gen: NUM_CH must be in 1..32");
  end

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    // Channels are decorrelated by xoring the channel index into the seed; zero would lock the LFSR.
    localparam logic [LFSR_W-1:0] CH_XOR  = LFSR_W'(c << 1);
    localparam logic [LFSR_W-1:0] RST_RAW = SEED ^ CH_XOR;
    localparam logic [LFSR_W-1:0] RST_VAL = (RST_RAW == '0) ? {LFSR_W{1'b1}} : RST_RAW;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, load_raw, load_val;
    logic [3:0]        phase_q;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              mask_q, mask_d, guard_q, guard_d;
    logic              cand;

    assign load_raw = seed ^ CH_XOR;
    assign load_val = (load_raw == '0) ? {LFSR_W{1'b1}} : load_raw;
    assign lfsr_d   = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[TAP-1]};

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
      cand = 1'b0;
      unique case (mode_s)
        MODE_OFF:    cand = 1'b0;
        MODE_RANDOM: cand = (lfsr_q[3:0] < density);
        MODE_BURST:  cand = (phase_q < density);
        MODE_FORCE:  cand = 1'b1;
      endcase
    end

    always_comb begin
      mask_d  = 1'b0;
      guard_d = 1'b0;
      run_d   = '0;
      if (cand && GUARD_EN && (run_q == RUN_MAX)) begin
        guard_d = 1'b1;
      end else if (cand) begin
        mask_d = 1'b1;
        run_d  = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
      end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        lfsr_q  <= RST_VAL;
        phase_q <= '0;
        run_q   <= '0;
        mask_q  <= 1'b0;
        guard_q <= 1'b0;
      end else if (seed_load) begin
        lfsr_q  <= load_val;
        phase_q <= '0;
        run_q   <= '0;
        mask_q  <= 1'b0;
        guard_q <= 1'b0;
      end else begin
        lfsr_q  <= lfsr_d;
        phase_q <= phase_q + 4'd1;
        run_q   <= run_d;
        mask_q  <= mask_d;
        guard_q <= guard_d;
      end
    end

    assign mask[c]      = mask_q;
    assign guard_hit[c] = guard_q;
  end

endmodule

// File: tb/tb_random_mask_gen.sv
// Scoreboard bench for random_mask_gen: two configurations share stimulus; expectations come from
// hand-derived vectors for the deterministic modes and a reference LFSR model for random mode.
module tb_random_mask_gen;

  typedef struct packed {
    logic [1:0] mask_a;
    logic [1:0] guard_a;
    logic       mask_b;
    logic       guard_b;
  } exp_t;

  localparam exp_t ZERO = '0;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  mode;
  logic [3:0]  density;
  logic        seed_load;
  logic [22:0] seed_a;
  logic [6:0]  seed_b;
  logic [1:0]  mask_a, guard_a;
  logic [0:0]  mask_b, guard_b;

  always #5 clk = ~clk;

  // Config A: two 23-bit channels, run guard of 8.
  random_mask_gen #(.NUM_CH(2), .LFSR_W(23), .SEED(23'h7FFFFF), .MAX_RUN(8)) u_a (
    .clk(clk), .resetn(resetn), .mode(mode), .density(density),
    .seed_load(seed_load), .seed(seed_a), .mask(mask_a), .guard_hit(guard_a)
  );

  // Config B: one 7-bit channel (period 127), guard disabled.
  random_mask_gen #(.NUM_CH(1), .LFSR_W(7), .SEED(7'h7F), .MAX_RUN(0)) u_b (
    .clk(clk), .resetn(resetn), .mode(mode), .density(density),
    .seed_load(seed_load), .seed(seed_b), .mask(mask_b), .guard_hit(guard_b)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [30:0] m_lfsr_a [2];
  int          m_phase_a [2];
  int          m_run_a [2];
  logic [30:0] m_lfsr_b;
  int          m_phase_b, m_run_b;

  task automatic ch_model(input int w, input int tap, input int max_run,
                          input logic [30:0] rst_val, input logic [30:0] load_val,
                          inout logic [30:0] lfsr, inout int phase, inout int run,
                          output logic m, output logic g);
    logic [30:0] msk, tmp;
    logic        cand;
    msk = 31'((32'd1 << w) - 32'd1);
    m = 1'b0;
    g = 1'b0;
    if (!resetn || seed_load) begin
      tmp   = (!resetn ? rst_val : load_val) & msk;
      lfsr  = (tmp == '0) ? msk : tmp;
      phase = 0;
      run   = 0;
    end else begin
      case (mode)
        2'd0:    cand = 1'b0;
        2'd1:    cand = (lfsr[3:0] < density);
        2'd2:    cand = (phase < int'(density));
        default: cand = 1'b1;
      endcase
      if (cand && max_run != 0 && run == max_run) begin
        g   = 1'b1;
        run = 0;
      end else if (cand) begin
        m = 1'b1;
        if (run < max_run) run++;
      end else begin
        run = 0;
      end
      lfsr  = ((lfsr << 1) | 31'(lfsr[w-1] ^ lfsr[tap-1])) & msk;
      phase = (phase + 1) % 16;
    end
  endtask

  task automatic model_advance(output exp_t e);
    logic m, g;
    e = '0;
    for (int c = 0; c < 2; c++) begin
      ch_model(23, 18, 8, 31'(32'h7FFFFF ^ (c << 1)), 31'({8'b0, seed_a} ^ 32'(c << 1)),
               m_lfsr_a[c], m_phase_a[c], m_run_a[c], m, g);
      e.mask_a[c]  = m;
      e.guard_a[c] = g;
    end
    ch_model(7, 6, 0, 31'h7F, {24'b0, seed_b}, m_lfsr_b, m_phase_b, m_run_b, m, g);
    e.mask_b  = m;
    e.guard_b = g;
  endtask

  function automatic exp_t mk(input logic [1:0] ma, input logic [1:0] ga, input logic mb, input logic gb);
    exp_t e;
    e.mask_a  = ma;
    e.guard_a = ga;
    e.mask_b  = mb;
    e.guard_b = gb;
    return e;
  endfunction

  // One clock of stimulus: inputs already set by the caller after a negedge.
  task automatic step(input exp_t hand, input bit use_model);
    exp_t em;
    model_advance(em);
    sb_q.push_back(use_model ? em : hand);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compares every registered output one delta past the edge it was produced on.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("mask_a",  32'(mask_a),  32'(e.mask_a));
        check("guard_a", 32'(guard_a), 32'(e.guard_a));
        check("mask_b",  32'(mask_b),  32'(e.mask_b));
        check("guard_b", 32'(guard_b), 32'(e.guard_b));
      end
    end
  end

  initial begin
    logic ma, ga, mb;
    int   p;
    resetn = 1'b0; mode = 2'b01; density = 4'd15; seed_load = 1'b0;
    seed_a = '0; seed_b = '0;

    // Cold reset, then random mode d=15: ch0 r=15 -> 0, ch1 (0x7FFFFD) r=13 -> 1, B r=15 -> 0.
    repeat (3) step(ZERO, 0);
    resetn = 1'b1;
    step(mk(2'b10, 2'b00, 1'b0, 1'b0), 0);
    step(mk(2'b11, 2'b00, 1'b1, 1'b0), 0);
    repeat (998) step(ZERO, 1);
    density = 4'd4;
    repeat (200) step(ZERO, 1);
    density = 4'd0;
    repeat (40) step(ZERO, 0);

    // Burst d=4: four ones then twelve zeros.
    resetn = 1'b0; step(ZERO, 0); resetn = 1'b1;
    mode = 2'b10; density = 4'd4;
    for (int i = 0; i < 32; i++) begin
      mb = ((i % 16) < 4);
      step(mk({mb, mb}, 2'b00, mb, 1'b0), 0);
    end
    density = 4'd0;
    repeat (32) step(ZERO, 0);

    // Burst d=12: A gets 8 ones, guard, 3 ones, 4 zeros; B (no guard) 12 ones, 4 zeros.
    resetn = 1'b0; step(ZERO, 0); resetn = 1'b1;
    density = 4'd12;
    for (int i = 0; i < 32; i++) begin
      p  = i % 16;
      ma = (p < 8) || (p > 8 && p < 12);
      ga = (p == 8);
      mb = (p < 12);
      step(mk({ma, ma}, {ga, ga}, mb, 1'b0), 0);
    end

    // Force-on: A repeats 8 ones then a guard cycle; B constant one.
    resetn = 1'b0; step(ZERO, 0); resetn = 1'b1;
    mode = 2'b11;
    for (int i = 0; i < 27; i++) begin
      ma = ((i % 9) < 8);
      ga = !ma;
      step(mk({ma, ma}, {ga, ga}, 1'b1, 1'b0), 0);
    end

    // Reset mid-run at run=5 (seed_load also high) restarts identically to a cold reset.
    resetn = 1'b0; step(ZERO, 0); resetn = 1'b1;
    repeat (5) step(mk(2'b11, 2'b00, 1'b1, 1'b0), 0);
    resetn = 1'b0; seed_load = 1'b1;
    step(ZERO, 0);
    resetn = 1'b1; seed_load = 1'b0; mode = 2'b01; density = 4'd15;
    step(mk(2'b10, 2'b00, 1'b0, 1'b0), 0);
    step(mk(2'b11, 2'b00, 1'b1, 1'b0), 0);
    repeat (100) step(ZERO, 1);

    // seed_load with seed=0, held two cycles in force mode: mask held low, zero seeds map to all ones.
    mode = 2'b11; seed_load = 1'b1; seed_a = '0; seed_b = '0;
    repeat (2) step(ZERO, 0);
    seed_load = 1'b0; mode = 2'b01; density = 4'd15;
    // ch0 0x7FFFFF r=15 -> 0; ch1 0x000002 r=2 -> 1, then 0x000004 r=4 -> 1.
    step(mk(2'b10, 2'b00, 1'b0, 1'b0), 0);
    step(mk(2'b11, 2'b00, 1'b1, 1'b0), 0);
    repeat (300) step(ZERO, 1);

    // seed=2 zeroes ch1's xored seed, which must also fall back to all ones.
    seed_a = 23'h000002; seed_b = 7'h02; seed_load = 1'b1;
    step(ZERO, 0);
    seed_load = 1'b0; density = 4'd4;
    repeat (100) step(ZERO, 1);

    repeat (2) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/random_mask_gen.md
Name: random_mask_gen

Overview:
- Multi-channel, parametrised pseudo-random stall-mask generator for the delay-RAM interface.
- Each channel has its own maximal-length LFSR and produces a registered 1-bit mask. The RAM interface uses that mask to insert stall cycles on its channel.
- Adds runtime-programmable stall density, a deterministic burst mode, runtime reseeding, and a bounded-run guard so no channel can stall indefinitely.

Parameters:
- NUM_CH, 2, number of independent mask channels; legal range 1..32.
- LFSR_W, 23, LFSR width; legal values are 7, 15, 23 and 31 only, anything else is an elaboration error.
- SEED, {LFSR_W{1'b1}}, reset seed for channel 0.
- MAX_RUN, 8, maximum consecutive asserted mask cycles per channel; 0 disables the guard.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- mode  in  2  00 off, 01 random, 10 burst, 11 force-on
- density  in  4  stall density d (0..15)
- seed_load  in  1  single-cycle reseed strobe
- seed  in  LFSR_W  reseed value
- mask  out  NUM_CH  registered stall mask, one bit per channel
- guard_hit  out  NUM_CH  one-cycle pulse when the run guard suppresses a stall

Behaviour:
- Clocking and reset:
  - resetn is synchronous and active-low; clock is clk. All state updates on the posedge of clk.
  - Priority order: reset, then seed_load, then normal operation.
- Reset state:
  - lfsr[c] = SEED ^ (c<<1). If that value is zero, substitute all ones.
  - phase[c] = 0 and run[c] = 0.
  - mask = 0 and guard_hit = 0.
- LFSR (per channel):
  - Fibonacci, shift left: next = {lfsr[W-2:0], lfsr[W-1]^lfsr[T-1]}.
  - Tap T per width: W=7→T=6, W=15→T=14, W=23→T=18, W=31→T=28 (trinomials x^W+x^T+1, maximal length).
  - Advances every non-reset, non-seed_load cycle, in every mode, so the sequence position is independent of mode.
- Burst phase counter (per channel):
  - phase[c] is 4-bit and increments every cycle in every mode.
  - Wraps 15→0.
- Candidate stall cand[c], computed from current state:
  - Mode 00: 0.
  - Mode 01: lfsr[c][3:0] < density.
  - Mode 10: phase[c] < density.
  - Mode 11: 1.
  - density = 0 gives cand = 0 in modes 01 and 10.
  - density = 4 in mode 01 gives a stall rate of about 1/4.
- Guard and mask register (per channel):
  - If cand = 1 and MAX_RUN != 0 and run = MAX_RUN: mask <= 0, guard_hit <= 1, run <= 0.
  - Else if cand = 1: mask <= 1, guard_hit <= 0, run <= run+1 (saturating at MAX_RUN).
  - Else: mask <= 0, guard_hit <= 0, run <= 0.
  - run width is clog2(MAX_RUN+1), minimum 1.
- Latency:
  - mask reflects state one cycle earlier (cand is registered).
  - mode and density changes are visible on mask at the first edge after they are sampled; there is no pipeline beyond that.
- seed_load:
  - lfsr[c] <= seed ^ (c<<1), with zero replaced by all ones.
  - phase <= 0, run <= 0, mask <= 0, guard_hit <= 0.
  - seed_load held for multiple cycles keeps reloading, and mask stays 0.
- Reset mid-operation: all state returns to reset values at the next edge, regardless of mode or seed_load.
- Channels are fully independent except that mode, density and seed are shared.

Test Plan:
- Reset with LFSR_W=23, SEED all ones, NUM_CH=1, mode=01, density=15, MAX_RUN=0, then release → first edge mask=0 (lfsr 0x7FFFFF, r=15); second edge mask=1 (lfsr 0x7FFFFE, r=14); cycle-exact match to a reference-model trace over 1000 cycles.
- mode=10, density=4, MAX_RUN=0 after reset → mask pattern 1,1,1,1 followed by twelve 0s, repeating with period 16; density=0 gives mask=0 forever.
- mode=10, density=12, MAX_RUN=8 → per period: 8 ones, then 0 with guard_hit=1, then 3 ones, then 4 zeros; guard_hit high exactly once per 16 cycles.
- mode=11, MAX_RUN=8 → repeating 8×1 then 1×0, guard_hit pulsing every 9th cycle. MAX_RUN=0 → mask constant 1 with guard_hit=0.
- seed_load with seed=0, NUM_CH=2 → ch0 lfsr reloads to all ones and ch1 to 0x000002, mask=0 that cycle; the sequence then matches a fresh reset with those seeds; no lock-up over 2^LFSR_W−1 steps (run with LFSR_W=7, period 127).
- Assert resetn low mid-run in mode 11 with run=5 → next edge mask=0 and run=0; after release, the sequence restarts identically to a cold reset.
